// File: rtl/trilha_colisao_pkg.sv
// Game-grid constants shared by the player, border and trail logic.
// Also holds the cell addressing helpers used for both moves and rendering.
package trilha_colisao_pkg;

    localparam int CELULA = 8;
    localparam int CEL_SH = $clog2(CELULA);
    localparam int COLS   = 80;
    localparam int LINHAS = 60;
    localparam int GRADE  = COLS * LINHAS;
    localparam int ADDR_W = 13;

    localparam int CX_MIN = 2;
    localparam int CX_MAX = 77;
    localparam int CY_MIN = 2;
    localparam int CY_MAX = 57;

    localparam logic [7:0] COR_R = 8'd0;
    localparam logic [7:0] COR_G = 8'd255;
    localparam logic [7:0] COR_B = 8'd255;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {LIMPA, ESPERA, LE, VERIFICA, FIM} estado_t;

    // cy*80 + cx without a multiplier
    function automatic addr_t cell_addr(input logic [9:0] x, input logic [9:0] y);
        addr_t cx;
        addr_t cy;
        cx = addr_t'(x >> CEL_SH);
        cy = addr_t'(y >> CEL_SH);
        return (cy << 6) + (cy << 4) + cx;
    endfunction

    function automatic logic fora_arena(input logic [9:0] x, input logic [9:0] y);
        logic [9:0] cx;
        logic [9:0] cy;
        cx = x >> CEL_SH;
        cy = y >> CEL_SH;
        return (cx < 10'(CX_MIN)) || (cx > 10'(CX_MAX)) ||
               (cy < 10'(CY_MIN)) || (cy > 10'(CY_MAX));
    endfunction

endpackage

// File: rtl/trilha_colisao_if.sv
// Move strobe, render request and status/colour bundle of the trail block.
interface trilha_colisao_if;

    logic       pos_valida;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [7:0] OUT_R;
    logic [7:0] OUT_G;
    logic [7:0] OUT_B;
    logic       colisao;
    logic       pronto;
    logic       ocupado;

    modport master (
        output pos_valida, pos_x, pos_y, next_x, next_y,
        input  OUT_R, OUT_G, OUT_B, colisao, pronto, ocupado
    );

    modport slave (
        input  pos_valida, pos_x, pos_y, next_x, next_y,
        output OUT_R, OUT_G, OUT_B, colisao, pronto, ocupado
    );

endinterface

// File: rtl/trilha_colisao_ram.sv
// 4800x1 occupancy grid: port A read/write (read-first), port B read-only.
module trilha_ram
    import trilha_colisao_pkg::*;
(
    input  logic  clk_i,
    input  logic  we_a_i,
    input  addr_t addr_a_i,
    input  logic  wd_a_i,
    output logic  rd_a_o,
    input  addr_t addr_b_i,
    output logic  rd_b_o
);

    logic mem [GRADE];
    logic rd_a_q;
    logic rd_b_q;

    // Addresses past the grid (VGA blanking, off-screen moves) read as empty
    always_ff @(posedge clk_i) begin
        if (we_a_i && (addr_a_i < addr_t'(GRADE)))
            mem[addr_a_i] <= wd_a_i;
        rd_a_q <= (addr_a_i < addr_t'(GRADE)) ? mem[addr_a_i] : 1'b0;
    end

    always_ff @(posedge clk_i) begin
        rd_b_q <= (addr_b_i < addr_t'(GRADE)) ? mem[addr_b_i] : 1'b0;
    end

    assign rd_a_o = rd_a_q;
    assign rd_b_o = rd_b_q;

endmodule

// File: rtl/trilha_colisao.sv
// Trail memory and collision detector: burns each visited cell, flags
// re-entry or arena exit, and returns the trail colour for the VGA pixel.
module trilha_colisao
    import trilha_colisao_pkg::*;
(
    input  logic            VGA_CLK,
    input  logic            reset,
    trilha_colisao_if.slave bus
);

    estado_t    state_q, state_d;
    addr_t      cnt_q, cnt_d;
    addr_t      addr_q, addr_d;
    logic       fora_q, fora_d;
    logic       ocupado_q, ocupado_d;
    logic       colisao_q, colisao_d;
    logic [7:0] r_q, g_q, b_q;

    addr_t addr_a, addr_b;
    logic  we_a, wd_a, rd_a, rd_b;
    logic  pronto;

    assign pronto = (state_q != LIMPA);
    assign addr_b = cell_addr(bus.next_x, bus.next_y);

    trilha_ram u_ram (
        .clk_i    (VGA_CLK),
        .we_a_i   (we_a),
        .addr_a_i (addr_a),
        .wd_a_i   (wd_a),
        .rd_a_o   (rd_a),
        .addr_b_i (addr_b),
        .rd_b_o   (rd_b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        fora_d  = fora_q;
        addr_a  = addr_q;
        we_a    = 1'b0;
        wd_a    = 1'b0;
        unique case (state_q)
            LIMPA: begin
                we_a   = 1'b1;
                addr_a = cnt_q;
                if (cnt_q == addr_t'(GRADE - 1)) begin
                    cnt_d   = '0;
                    state_d = ESPERA;
                end else begin
                    cnt_d = cnt_q + addr_t'(1);
                end
            end
            ESPERA: begin
                if (bus.pos_valida) begin
                    addr_d  = cell_addr(bus.pos_x, bus.pos_y);
                    fora_d  = fora_arena(bus.pos_x, bus.pos_y);
                    state_d = LE;
                end
            end
            LE:       state_d = VERIFICA;
            VERIFICA: begin
                if (rd_a || fora_q) begin
                    state_d = FIM;
                end else begin
                    we_a    = 1'b1;
                    wd_a    = 1'b1;
                    state_d = ESPERA;
                end
            end
            FIM:      state_d = FIM;
            default:  state_d = LIMPA;
        endcase
        // A reset landing on VERIFICA must not leave a burned cell behind
        if (reset)
            we_a = 1'b0;
    end

    // Status outputs trail the FSM by one edge so a move reads busy for
    // three cycles and its verdict appears on the third edge after the strobe.
    assign ocupado_d = (state_q == ESPERA && bus.pos_valida) ||
                       (state_q == LE) || (state_q == VERIFICA);
    assign colisao_d = (state_q == FIM);

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            state_q   <= LIMPA;
            cnt_q     <= '0;
            addr_q    <= '0;
            fora_q    <= 1'b0;
            ocupado_q <= 1'b0;
            colisao_q <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            fora_q    <= fora_d;
            ocupado_q <= ocupado_d;
            colisao_q <= colisao_d;
            r_q       <= (pronto && rd_b) ? COR_R : 8'd0;
            g_q       <= (pronto && rd_b) ? COR_G : 8'd0;
            b_q       <= (pronto && rd_b) ? COR_B : 8'd0;
        end
    end

    assign bus.OUT_R   = r_q;
    assign bus.OUT_G   = g_q;
    assign bus.OUT_B   = b_q;
    assign bus.colisao = colisao_q;
    assign bus.ocupado = ocupado_q;
    assign bus.pronto  = pronto;

endmodule

// File: tb/tb_trilha_colisao.sv
// Bench for trilha_colisao: vector table of moves, hand corner sequences,
// and random move streams checked against a cycle-counting grid model.
module tb_trilha_colisao;

    logic clk;
    logic rst;
    int   errs;
    int   checks;

    trilha_colisao_if bus ();

    trilha_colisao dut (
        .VGA_CLK (clk),
        .reset   (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst_before;
        int x;
        int y;
        bit col;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint rgb();
        return longint'({bus.OUT_R, bus.OUT_G, bus.OUT_B});
    endfunction

    task automatic reset_clear(input bit poke);
        int n;
        int seen;
        rst = 1'b1;
        bus.pos_valida = 1'b0;
        tick();
        chk("rst_pronto", bus.pronto, 0);
        chk("rst_ocupado", bus.ocupado, 0);
        chk("rst_colisao", bus.colisao, 0);
        chk("rst_out", rgb(), 0);
        rst = 1'b0;
        n = 0;
        seen = 0;
        while (!bus.pronto && n < 6000) begin
            if (poke) begin
                bus.pos_valida = (n == 100);
                bus.pos_x = 10'd219;
                bus.pos_y = 10'd239;
            end
            tick();
            n++;
            if (bus.ocupado) seen = 1;
        end
        bus.pos_valida = 1'b0;
        chk("clear_cycles", n, 4800);
        chk("clear_ocupado", seen, 0);
    endtask

    task automatic move(input int x, input int y, input bit exp_col);
        bus.pos_x = 10'(x);
        bus.pos_y = 10'(y);
        bus.pos_valida = 1'b1;
        tick();
        bus.pos_valida = 1'b0;
        chk("ocupado_k", bus.ocupado, 1);
        tick();
        chk("ocupado_k1", bus.ocupado, 1);
        tick();
        chk("ocupado_k2", bus.ocupado, 1);
        chk("colisao_k2", bus.colisao, 0);
        tick();
        chk("colisao_k3", bus.colisao, exp_col);
        chk("ocupado_k3", bus.ocupado, 0);
    endtask

    task automatic render(input int x, input int y, input bit on, input string nm);
        bus.next_x = 10'(x);
        bus.next_y = 10'(y);
        tick();
        tick();
        chk(nm, rgb(), on ? 64'h00FFFF : 64'h0);
    endtask

    task automatic rand_round(input int ncyc);
        bit g [4800];
        int ready;
        int acc;
        int coledge;
        bit dead;
        foreach (g[i]) g[i] = 1'b0;
        ready = 0;
        acc = -100;
        coledge = 0;
        dead = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            int x;
            int y;
            int cx;
            int cy;
            bit s;
            s = ($urandom_range(0, 2) == 0);
            x = $urandom_range(8, 71);
            y = $urandom_range(8, 71);
            bus.pos_valida = s;
            bus.pos_x = 10'(x);
            bus.pos_y = 10'(y);
            tick();
            if (s && !dead && c >= ready) begin
                cx = x / 8;
                cy = y / 8;
                acc = c;
                ready = c + 3;
                if (cx < 2 || cx > 77 || cy < 2 || cy > 57 || g[cy*80 + cx]) begin
                    dead = 1'b1;
                    coledge = c + 3;
                end else begin
                    g[cy*80 + cx] = 1'b1;
                end
            end
            chk("rnd_ocupado", bus.ocupado, (c - acc <= 2));
            chk("rnd_colisao", bus.colisao, (dead && c >= coledge));
        end
        bus.pos_valida = 1'b0;
        tick();
        tick();
        tick();
        for (int cy = 0; cy < 10; cy++)
            for (int cx = 0; cx < 10; cx++)
                render(cx*8 + $urandom_range(0, 7), cy*8 + $urandom_range(0, 7),
                       g[cy*80 + cx], "rnd_render");
    endtask

    initial begin
        errs = 0;
        checks = 0;
        rst = 1'b1;
        bus.pos_valida = 1'b0;
        bus.pos_x = '0;
        bus.pos_y = '0;
        bus.next_x = '0;
        bus.next_y = '0;

        tbl[0] = '{1'b1, 219, 239, 1'b0};
        tbl[1] = '{1'b0, 227, 239, 1'b0};
        tbl[2] = '{1'b0,  16,  16, 1'b0};
        tbl[3] = '{1'b0, 623, 463, 1'b0};
        tbl[4] = '{1'b0, 219, 239, 1'b1};
        tbl[5] = '{1'b1,  11, 100, 1'b1};
        tbl[6] = '{1'b1, 627, 100, 1'b1};
        tbl[7] = '{1'b1, 100,  15, 1'b1};
        tbl[8] = '{1'b1, 100, 471, 1'b1};

        // Clear with a strobe poked mid-clear, then sweep every cell
        reset_clear(1'b1);
        for (int i = 0; i < 4802; i++) begin
            if (i < 4800) begin
                bus.next_x = 10'((i % 80) * 8 + $urandom_range(0, 7));
                bus.next_y = 10'((i / 80) * 8 + $urandom_range(0, 7));
            end
            tick();
            if (i >= 1) chk("sweep_out", rgb(), 0);
        end

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst_before) reset_clear(1'b0);
            move(tbl[i].x, tbl[i].y, tbl[i].col);
            if (!tbl[i].col) render(tbl[i].x, tbl[i].y, 1'b1, "tbl_render");
            if (i == 4) begin
                bus.pos_x = 10'd300;
                bus.pos_y = 10'd300;
                bus.pos_valida = 1'b1;
                tick();
                bus.pos_valida = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    chk("fim_colisao", bus.colisao, 1);
                    chk("fim_ocupado", bus.ocupado, 0);
                    tick();
                end
                render(300, 300, 1'b0, "fim_no_write");
                render(216, 232, 1'b1, "fim_trail_kept");
            end
        end

        // Back-to-back strobes: the second one is dropped
        reset_clear(1'b0);
        bus.pos_x = 10'd219;
        bus.pos_y = 10'd239;
        bus.pos_valida = 1'b1;
        tick();
        bus.pos_x = 10'd300;
        bus.pos_y = 10'd300;
        tick();
        bus.pos_valida = 1'b0;
        chk("b2b_ocupado", bus.ocupado, 1);
        tick();
        tick();
        chk("b2b_colisao", bus.colisao, 0);
        chk("b2b_ocupado_end", bus.ocupado, 0);
        render(216, 232, 1'b1, "b2b_first");
        render(300, 300, 1'b0, "b2b_second");

        // Reset landing on VERIFICA of a colliding move
        bus.pos_x = 10'd219;
        bus.pos_y = 10'd239;
        bus.pos_valida = 1'b1;
        tick();
        bus.pos_valida = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midmove_pronto", bus.pronto, 0);
        chk("midmove_ocupado", bus.ocupado, 0);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("midmove_colisao", bus.colisao, 0);
        end
        // Reset again mid-clear: the clear starts over from address 0
        repeat (1000) tick();
        reset_clear(1'b0);
        render(219, 239, 1'b0, "midmove_cell");

        for (int r = 0; r < 3; r++) begin
            reset_clear(1'b0);
            rand_round(300);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
